truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Stimulus/capture end of a 3-input truth-table block: drives every input combination
//  {a,b,c} onto the DUT, waits a settle time, samples the DUT output s and assembles the
//  full 8-entry truth table.
//  - Compares the captured table against an expected table and flags match/mismatch.
//  - Sits beside any combinational truth-table block as an on-chip self-checker.
// PARAMETERS
//  N_IN      3             number of DUT inputs; table depth = 2**N_IN
//  SETTLE    1             cycles stimulus is held before sampling (legal range >= 1)
//  EXPECTED  8'b0100_1100  expected table, bit i = s for {a,b,c} == i
// PORTS
//  clk       in   1        single clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  start     in   1        1-cycle request to begin a scan; ignored while busy
//  s_in      in   1        DUT output s, combinational from stim
//  stim      out  N_IN     drives {a,b,c} of the DUT (MSB = a)
//  busy      out  1        high from the cycle after start until done
//  done      out  1        1-cycle pulse, scan complete, table/match valid
//  table_out out  2**N_IN  captured table, bit i = s sampled with stim == i
//  match     out  1        table_out == EXPECTED; updated with done, held until next done
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, stim=0, busy=0, done=0,
//    table_out=0, match=0, idx=0, cnt=0.
//  - All outputs are registered.
//  - FSM states: IDLE, DRIVE, SAMPLE, DONE.
//  - IDLE
//    - start=1 at edge k -> DRIVE; stim<=0, idx<=0, cnt<=0, busy<=1.
//    - table_out is cleared at this edge; match keeps its previous value.
//  - DRIVE
//    - stim held at idx; cnt increments each cycle.
//    - When cnt==SETTLE-1 -> SAMPLE.
//  - SAMPLE
//    - table_out[idx]<=s_in.
//    - If idx==2**N_IN-1 -> DONE; else idx<=idx+1, stim<=idx+1, cnt<=0 -> DRIVE.
//  - DONE
//    - done=1 for exactly one cycle; busy=0; match holds the final comparison.
//    - match is computed on the complete table, including the final sample.
//    - Next edge -> IDLE.
//  - Latency: done is high in the cycle following edge k + 2**N_IN*(SETTLE+1).
//    - Default parameters: 16 cycles after the start edge.
//  - Stimulus ordering: ascending 0 .. 2**N_IN-1; stim returns to 0 in IDLE and stays there.
//  - start while busy (DRIVE/SAMPLE/DONE): ignored; no restart, no queueing.
//  - start in the same cycle done is high: ignored.
//    - A new scan requires start in IDLE.
//  - Reset mid-scan: immediate return to the reset values; no done pulse; partial table lost.
//  - Widths
//    - idx is N_IN+1 bits internally so the last-index compare cannot wrap.
//    - cnt is $clog2(SETTLE+1) bits.
// STRUCTURE
//  - Shared header truth_table_pkg.vh: FSM state localparams (IDLE=2'd0, DRIVE=2'd1,
//    SAMPLE=2'd2, DONE=2'd3) and default EXPECTED constant, shared with the DUT wrappers.
//  - One natural sub-module: settle_counter.
//    - Loadable down/up counter with a terminal flag.
//    - Parameterised by SETTLE.
//  - FSM, index register and capture/compare logic stay in this module.
// TESTING
//  - Reset: assert rst_n=0 mid-DRIVE -> all outputs 0 within the same cycle;
//    no done after release.
//  - Golden DUT (s=1 for 010,011,110): start=1 -> stim steps 0..7 with 2 cycles each;
//    done at cycle 16; table_out=8'h4C, match=1.
//  - Faulty DUT (s stuck at 0): start -> done at cycle 16; table_out=8'h00, match=0.
//  - SETTLE=3: start -> each stim value held 4 cycles; done at cycle 32;
//    table_out equals the DUT table.
//  - start pulsed at cycles 5 and 16 (the done cycle) -> single scan, single done,
//    no second scan.
//  - Back-to-back: start the cycle after done (IDLE) -> second scan completes;
//    table_out is rebuilt from 0; match reflects the second scan only.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and defaults for the truth-table scanner: FSM state encoding
// and the default expected table.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  localparam int unsigned DEF_N_IN     = 3;
  localparam logic [7:0]  DEF_EXPECTED = 8'b0100_1100;

endpackage

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle timer: cleared while not counting, increments while enabled, and
// flags the last settle cycle so the FSM can move to sampling.
module truth_table_scanner_settle_counter
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CW     = $clog2(SETTLE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign terminal = enable && (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// On-chip self-checker: walks every input combination of a combinational
// block, captures its output into a table and compares against EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start, stim parked at 0
// DRIVE  | stim held at idx while the DUT settles
// SAMPLE | capture s_in into table_out[idx], advance or finish
// DONE   | one-cycle done pulse, table_out/match valid
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned              N_IN     = DEF_N_IN,
  parameter int unsigned              SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]     EXPECTED = DEF_EXPECTED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   s_in,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match
);

  localparam int unsigned DEPTH = 1 << N_IN;

  scan_state_t          state, state_nxt;
  logic [N_IN:0]        idx;
  logic [N_IN:0]        idx_inc;
  logic                 last;
  logic                 settled;
  logic [DEPTH-1:0]     table_nxt;

  truth_table_scanner_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != DRIVE),
    .enable   (state == DRIVE),
    .terminal (settled)
  );

  // idx carries one spare bit so the last-index compare never wraps
  assign last    = (idx == (N_IN+1)'(DEPTH - 1));
  assign idx_inc = idx + 1'b1;

  always_comb begin
    table_nxt = table_out;
    table_nxt[idx[N_IN-1:0]] = s_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settled) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      match     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stim      <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            table_out <= '0;
          end
        end
        SAMPLE: begin
          table_out <= table_nxt;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= (table_nxt == EXPECTED);
          end else begin
            idx  <= idx_inc;
            stim <= idx_inc[N_IN-1:0];
          end
        end
        DONE: stim <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two scanners (SETTLE=1 and SETTLE=3) each
// probing a behavioural truth-table block whose table is chosen per scan.
module tb_truth_table_scanner;

  localparam logic [7:0] GOLDEN = 8'h4C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tt_a = 8'h00, tt_b = 8'h00;
  logic       s_a, s_b;
  logic [2:0] stim_a, stim_b;
  logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
  logic [7:0] table_a, table_b;

  int vectors = 0;
  int miscompares = 0;
  bit sel_b = 1'b0;
  logic model_match [2];

  logic [2:0] o_stim;
  logic       o_busy, o_done, o_match;
  logic [7:0] o_table;

  always #5 clk = ~clk;

  // behavioural combinational blocks under test
  assign s_a = tt_a[stim_a];
  assign s_b = tt_b[stim_b];

  always_comb begin
    o_stim  = sel_b ? stim_b  : stim_a;
    o_busy  = sel_b ? busy_b  : busy_a;
    o_done  = sel_b ? done_b  : done_a;
    o_match = sel_b ? match_b : match_a;
    o_table = sel_b ? table_b : table_a;
  end

  truth_table_scanner #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s_in(s_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .table_out(table_a), .match(match_a)
  );

  truth_table_scanner #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s_in(s_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .table_out(table_b), .match(match_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_start(input bit b, input logic v);
    if (b) start_b = v; else start_a = v;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_stim"},  32'(o_stim),  32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_table"}, 32'(o_table), 32'd0);
    chk({tag, "_match"}, 32'(o_match), 32'd0);
  endtask

  // Called at a negedge with the scanner idle; returns one cycle after done.
  // poke re-asserts start mid-scan and in the done cycle; both must be ignored.
  task automatic scan(input bit b, input logic [7:0] tt, input bit poke);
    int hold, total;
    logic [7:0] mask;
    logic exp_match;
    hold  = b ? 4 : 2;
    total = 8 * hold;
    sel_b = b;
    if (b) tt_b = tt; else tt_a = tt;
    drive_start(b, 1'b1);
    @(negedge clk);
    drive_start(b, 1'b0);
    for (int t = 0; t < total; t++) begin
      mask = 8'((1 << (t / hold)) - 1);
      chk("stim",        32'(o_stim),  32'(t / hold));
      chk("busy",        32'(o_busy),  32'd1);
      chk("done_early",  32'(o_done),  32'd0);
      chk("table_part",  32'(o_table), 32'(tt & mask));
      chk("match_held",  32'(o_match), 32'(model_match[b]));
      drive_start(b, poke && (t == 5));
      @(negedge clk);
    end
    exp_match = (tt == GOLDEN);
    chk("done",      32'(o_done),  32'd1);
    chk("busy_done", 32'(o_busy),  32'd0);
    chk("table",     32'(o_table), 32'(tt));
    chk("match",     32'(o_match), 32'(exp_match));
    model_match[b] = exp_match;
    drive_start(b, poke);
    @(negedge clk);
    drive_start(b, 1'b0);
    chk("done_once", 32'(o_done), 32'd0);
    chk("stim_idle", 32'(o_stim), 32'd0);
  endtask

  task automatic idle_check(input bit b, input int n);
    sel_b = b;
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_done", 32'(o_done), 32'd0);
      chk("idle_stim", 32'(o_stim), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_match[0] = 1'b0;
    model_match[1] = 1'b0;
    repeat (2) @(negedge clk);
    sel_b = 1'b0; check_outputs_zero("rst_a");
    sel_b = 1'b1; check_outputs_zero("rst_b");
    rst_n = 1'b1;
    @(negedge clk);

    // golden, stuck-at-0 back-to-back, then ignored restarts
    scan(1'b0, GOLDEN, 1'b0);
    scan(1'b0, 8'h00, 1'b0);
    scan(1'b0, GOLDEN, 1'b0);
    scan(1'b0, 8'($urandom), 1'b1);
    idle_check(1'b0, 20);
    for (int i = 0; i < 6; i++) begin
      scan(1'b0, ($urandom_range(0, 3) == 0) ? GOLDEN : 8'($urandom), 1'b0);
      idle_check(1'b0, $urandom_range(0, 3));
    end

    scan(1'b1, GOLDEN, 1'b0);
    scan(1'b1, 8'($urandom), 1'b1);
    idle_check(1'b1, 10);
    for (int i = 0; i < 3; i++) scan(1'b1, 8'($urandom), 1'b0);

    // reset in the middle of DRIVE after a matching scan
    scan(1'b0, GOLDEN, 1'b0);
    tt_a = 8'hFF;
    sel_b = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_table", 32'(o_table), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    model_match[0] = 1'b0;
    model_match[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1'b0, 25);
    scan(1'b0, GOLDEN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
